// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operation issuer.
// Holds the 4-bit AluOp encoding, the RV32I opcode/funct7 constants,
// the issuer state enum and a funct3-to-AluOp helper.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned INSTR_W  = 32;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } issue_state_e;

  // Default (funct7 = 0000000) mapping of funct3 to AluOp.
  function automatic logic [ALU_OP_W-1:0] base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP / OP-IMM decoder.
// Ports: instr (in) -> alu_op, use_imm, imm32, illegal (out).
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                use_imm,
  output logic [31:0]         imm32,
  output logic                illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register indices are not needed for decode.
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  // Opcode/funct decode; shift-immediates use the zero-extended shamt.
  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    imm32   = {{20{instr[31]}}, instr[31:20]};
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          alu_op = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        alu_op  = base_op(funct3);
        if (funct3 == 3'b001) begin
          imm32   = {27'd0, instr[24:20]};
          illegal = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          imm32 = {27'd0, instr[24:20]};
          if (funct7 == F7_ALT) begin
            alu_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Multicycle issuer in front of the combinational ALU.
// Accepts an instruction + operands (in_valid/in_ready), drives alu_a/alu_b/
// alu_op from registers for one EXEC cycle, captures alu_s and returns it with
// rd and an illegal flag (out_valid/out_ready).
// Ports: clk, rst (async, active-high); in_valid, in_ready, instr, rs1_data,
// rs2_data; alu_a, alu_b, alu_op, alu_s; out_valid, out_ready, out_result,
// out_rd, out_illegal.
// Option: ALU_ISSUE_BACK2BACK_EN lets DONE accept the next instruction on the
// same edge the result handshakes.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int unsigned      XLEN           = 32,
  parameter logic [XLEN-1:0]  ILLEGAL_RESULT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     alu_s,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [4:0]          out_rd,
  output logic                out_illegal
);

  issue_state_e state_q, state_d;

  logic [XLEN-1:0]     alu_a_q, alu_a_d;
  logic [XLEN-1:0]     alu_b_q, alu_b_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [XLEN-1:0]     out_result_q, out_result_d;
  logic [4:0]          out_rd_q, out_rd_d;
  logic                out_illegal_q, out_illegal_d;

  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_use_imm;
  logic [31:0]         dec_imm;
  logic                dec_illegal;
  logic                accept_c;

  alu_op_decode u_decode (
    .instr   (instr),
    .alu_op  (dec_op),
    .use_imm (dec_use_imm),
    .imm32   (dec_imm),
    .illegal (dec_illegal)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; an accept overrides the default progression.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept_c) state_d = dec_illegal ? ST_DONE : ST_EXEC;
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
`ifdef ALU_ISSUE_BACK2BACK_EN
    in_ready  = in_ready || (state_q == ST_DONE && out_ready);
`endif
    out_valid = (state_q == ST_DONE);
    accept_c  = in_valid && in_ready;
  end

  // Datapath next values: operands at accept, ALU result at the EXEC edge.
  // An illegal instruction leaves the ALU operand registers untouched.
  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    if (accept_c) begin
      out_rd_d      = instr[11:7];
      out_illegal_d = dec_illegal;
      if (dec_illegal) begin
        out_result_d = ILLEGAL_RESULT;
      end else begin
        alu_a_d  = rs1_data;
        alu_b_d  = dec_use_imm ? XLEN'(dec_imm) : rs2_data;
        alu_op_d = dec_op;
      end
    end
    if (state_q == ST_EXEC) out_result_d = alu_s;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= ALU_ADD;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: a reference model derived from the
// RV32I instruction semantics predicts each result; a monitor compares
// whenever out_valid is high and pops on the handshake.
`timescale 1ns/1ps
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_op_issuer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_s       (alu_s),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

`ifdef ALU_ISSUE_BACK2BACK_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  // Stand-in for the external single-cycle ALU.
  always_comb begin
    case (alu_op)
      4'b0000: alu_s = alu_a + alu_b;
      4'b1000: alu_s = alu_a - alu_b;
      4'b0001: alu_s = alu_a << alu_b[4:0];
      4'b0010: alu_s = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_s = {31'd0, alu_a < alu_b};
      4'b0100: alu_s = alu_a ^ alu_b;
      4'b0101: alu_s = alu_a >> alu_b[4:0];
      4'b1101: alu_s = 32'($signed(alu_a) >>> alu_b[4:0]);
      4'b0110: alu_s = alu_a | alu_b;
      4'b0111: alu_s = alu_a & alu_b;
      default: alu_s = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic        illegal;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          hs_edges[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: never
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [3:0]  last_op = '0;
  string       base_mn [8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Instruction semantics by mnemonic, independent of the AluOp datapath.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    string       mn;
    logic [31:0] b;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    opc = ins[6:0];
    f7  = ins[31:25];
    f3  = ins[14:12];
    mn  = "";
    b   = r2;
    if (opc == 7'b0110011) begin
      if (f7 == 7'd0) mn = base_mn[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) mn = "sub";
      else if (f7 == 7'h20 && f3 == 3'd5) mn = "sra";
    end else if (opc == 7'b0010011) begin
      b  = {{20{ins[31]}}, ins[31:20]};
      mn = base_mn[f3];
      if (f3 == 3'd1 && f7 != 7'd0) mn = "";
      if (f3 == 3'd5) begin
        b = {27'd0, ins[24:20]};
        if (f7 == 7'h20) mn = "sra";
        else if (f7 != 7'd0) mn = "";
      end
    end
    e.rd       = ins[11:7];
    e.illegal  = (mn == "");
    e.acc_edge = 0;
    e.a        = r1;
    e.b        = b;
    e.op       = 4'b0000;
    e.res      = 32'h0;
    case (mn)
      "add":  begin e.op = 4'b0000; e.res = r1 + b; end
      "sub":  begin e.op = 4'b1000; e.res = r1 - b; end
      "sll":  begin e.op = 4'b0001; e.res = r1 << b[4:0]; end
      "slt":  begin e.op = 4'b0010; e.res = ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0; end
      "sltu": begin e.op = 4'b0011; e.res = (r1 < b) ? 32'd1 : 32'd0; end
      "xor":  begin e.op = 4'b0100; e.res = r1 ^ b; end
      "srl":  begin e.op = 4'b0101; e.res = r1 >> b[4:0]; end
      "sra":  begin e.op = 4'b1101; e.res = 32'($signed(r1) >>> b[4:0]); end
      "or":   begin e.op = 4'b0110; e.res = r1 | b; end
      "and":  begin e.op = 4'b0111; e.res = r1 & b; end
      default: ;
    endcase
    return e;
  endfunction

  // Present one instruction; in_valid stays high afterwards until idle().
  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   n;
    @(negedge clk);
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("issue_accept", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    e = model(ins, r1, r2);
    e.acc_edge = cyc + 1;
    if (e.illegal) begin
      e.a  = last_a;
      e.b  = last_b;
      e.op = last_op;
    end else begin
      last_a  = e.a;
      last_b  = e.b;
      last_op = e.op;
    end
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: drives out_ready, compares the queue head while out_valid is high.
  initial begin : monitor
    exp_t e;
    bit   seen;
    seen = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      #2;
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          if (!seen) begin
            chk("latency", 32'(cyc - e.acc_edge + 1), e.illegal ? 32'd1 : 32'd2);
            seen = 1'b1;
          end
          chk("out_result", out_result, e.res);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_illegal", 32'(out_illegal), 32'(e.illegal));
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
          chk("alu_op", 32'(alu_op), 32'(e.op));
`ifdef ALU_ISSUE_BACK2BACK_EN
          chk("in_ready_done", 32'(in_ready), 32'(out_ready));
`else
          chk("in_ready_done", 32'(in_ready), 32'd0);
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_edges.push_back(cyc + 1);
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [6:0]  f7;
    rst      = 1'b1;
    in_valid = 1'b0;
    instr    = '0;
    rs1_data = '0;
    rs2_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);

    // Directed cases.
    issue(32'h0020_81B3, 32'd5, 32'd7);           // add x3,x1,x2
    idle(3);
    issue(32'h4020_81B3, 32'd5, 32'd7);           // sub x3,x1,x2
    idle(3);
    issue(32'h4040_D293, 32'h8000_0000, 32'd0);   // srai x5,x1,4
    idle(3);
    rdy_mode = 2;
    issue(32'hFFF0_0093, 32'd0, 32'd0);           // addi x1,x0,-1, result held
    idle(6);
    rdy_mode = 0;
    drain();
    issue(32'h0000_0003, 32'd1, 32'd2);           // load opcode: illegal
    idle(3);
    drain();

    // Reset during EXEC drops the in-flight add.
    issue(32'h0020_81B3, 32'd5, 32'd7);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    last_a  = '0;
    last_b  = '0;
    last_op = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_exec_alu_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rst_exec_out_valid", 32'(out_valid), 32'd0);
      chk("rst_exec_in_ready", 32'(in_ready), 32'd1);
    end

    // Throughput with a continuously valid source and an always-ready sink.
    hs_edges.delete();
    for (int i = 0; i < 4; i++) issue(32'h0020_81B3, 32'(i), 32'd3);
    idle(1);
    drain();
    chk("throughput_count", 32'(hs_edges.size()), 32'd4);
    if (hs_edges.size() >= 4)
      chk("throughput_span", 32'(hs_edges[3] - hs_edges[0]), 32'(3 * PERIOD));

    // Randomized mix with a randomly stalling sink.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: opc = 7'b0110011;
        4, 5, 6, 7: opc = 7'b0010011;
        default:    opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
      issue(ins,
            ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom),
            ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(1);
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
